// File: rtl/mul_booth_seq.sv
// Sequential Booth multiplier (start/busy/done) returning a full 2*WIDTH-bit product as HI/LO.
// Define MUL_BOOTH_RADIX4_EN for radix-4 (modified) Booth; default build is radix-2.
module mul_booth_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
`ifdef MUL_BOOTH_RADIX4_EN
    localparam int QW    = ((WIDTH + 2) / 2) * 2;
    localparam int UW    = QW + 2;
    localparam int STEPS = QW / 2;
    localparam int SH    = 2;
`else
    localparam int QW    = WIDTH + 1;
    localparam int UW    = QW + 1;
    localparam int STEPS = QW;
    localparam int SH    = 1;
`endif
    localparam int ACC_W = UW + QW + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  state;
    logic signed [QW-1:0]    a_x;
    logic signed [UW-1:0]    u;
    logic [QW-1:0]           q;
    logic                    q_m1;
    logic [CNT_W-1:0]        cnt;

    logic signed [UW-1:0]    a_w;
    logic signed [UW-1:0]    sum;
    logic signed [UW-1:0]    u_n;
    logic [QW-1:0]           q_n;
    logic                    qm1_n;
    logic signed [ACC_W-1:0] acc_sh;
    logic [UW+QW-1:0]        prod_w;
    logic                    unused_prod;

    // Operands are widened by at least one bit so the most-negative signed value and
    // the largest unsigned value are both representable in the same signed frame.
    function automatic logic [QW-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return {{(QW - WIDTH){s & v[WIDTH-1]}}, v};
    endfunction

    assign a_w = {{(UW - QW){a_x[QW-1]}}, a_x};

`ifdef MUL_BOOTH_RADIX4_EN
    logic signed [UW-1:0] a2_w;
    assign a2_w = a_w <<< 1;

    always_comb begin
        sum = u;
        case ({q[1:0], q_m1})
            3'b001, 3'b010: sum = u + a_w;
            3'b011:         sum = u + a2_w;
            3'b100:         sum = u - a2_w;
            3'b101, 3'b110: sum = u - a_w;
            default:        sum = u;
        endcase
    end
`else
    always_comb begin
        sum = u;
        case ({q[0], q_m1})
            2'b01:   sum = u + a_w;
            2'b10:   sum = u - a_w;
            default: sum = u;
        endcase
    end
`endif

    assign acc_sh                = $signed({sum, q, q_m1}) >>> SH;
    assign {u_n, q_n, qm1_n}     = acc_sh;
    assign prod_w                = {u_n, q_n};
    assign unused_prod           = ^prod_w[UW+QW-1:2*WIDTH];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            cnt   <= '0;
            u     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            a_x   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_BUSY;
                        busy  <= 1'b1;
                        a_x   <= ext(A, is_signed);
                        u     <= '0;
                        q     <= ext(B, is_signed);
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    u    <= u_n;
                    q    <= q_n;
                    q_m1 <= qm1_n;
                    cnt  <= cnt + CNT_W'(1);
                    // Result is taken from the post-step value so HI/LO land with done.
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        HI    <= prod_w[2*WIDTH-1:WIDTH];
                        LO    <= prod_w[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_booth_seq.sv
// Bench for mul_booth_seq: cycle-level reference model for a WIDTH=32 instance plus a WIDTH=8 instance.
module tb_mul_booth_seq;
    localparam int W  = 32;
    localparam int W8 = 8;
`ifdef MUL_BOOTH_RADIX4_EN
    localparam int N32 = (W + 2) / 2;
    localparam int N8  = (W8 + 2) / 2;
`else
    localparam int N32 = W + 1;
    localparam int N8  = W8 + 1;
`endif

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done;
    logic [31:0] HI, LO;

    logic        start8 = 1'b0;
    logic        sgn8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    mul_booth_seq #(.WIDTH(W), .CNT_W(7)) dut (
        .clock(clock), .clear(clear), .start(start), .is_signed(is_signed),
        .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    mul_booth_seq #(.WIDTH(W8), .CNT_W(5)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .is_signed(sgn8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Full product of two w-bit operands, low 2*w bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        logic [63:0] mask, mask2;
        logic signed [63:0] ea, eb, p;
        mask  = (64'd1 << w) - 64'd1;
        mask2 = (64'd1 << (2 * w)) - 64'd1;
        ea = {32'b0, a} & mask;
        eb = {32'b0, b} & mask;
        if (s && a[w-1]) ea = ea | ~mask;
        if (s && b[w-1]) eb = eb | ~mask;
        p = ea * eb;
        return p & mask2;
    endfunction

    // Reference model: an accepted start yields N32 busy cycles then one done cycle.
    logic        m_busy = 1'b0, m_done = 1'b0, m_inflight = 1'b0, m_prev = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          cyc = 0, t_done = 0;

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_busy = 1'b0; m_done = 1'b0; m_inflight = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            cyc++;
            m_prev = m_busy;
            m_busy = 1'b0;
            m_done = 1'b0;
            if (m_inflight) begin
                if (cyc == t_done) begin
                    m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_inflight = 1'b0;
                end else begin
                    m_busy = 1'b1;
                end
            end
            if (!m_prev && start) begin
                {p_hi, p_lo} = ref_prod(A, B, is_signed, W);
                t_done = cyc + N32;
                m_inflight = 1'b1;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_busy", {63'b0, busy}, {63'b0, m_busy});
            check("cyc_done", {63'b0, done}, {63'b0, m_done});
            check("cyc_hi", {32'b0, HI}, {32'b0, m_hi});
            check("cyc_lo", {32'b0, LO}, {32'b0, m_lo});
        end
    end

    task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1; A = a; B = b; is_signed = s;
    endtask

    // Waits for done; inputs are scrambled meanwhile and optionally a stray start is pulsed.
    task automatic wait_done(input bit poke, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            start = poke && (n == 4);
            A = $urandom;
            B = $urandom;
            is_signed = 1'($urandom);
        end while (!done && n < 200);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string name, input bit poke, input bit b2b);
        int n;
        if (!b2b) @(negedge clock);
        go(a, b, s);
        wait_done(poke, n);
        check({name, "_latency"}, 64'(n), 64'(N32 + 1));
        check({name, "_hi"}, {32'b0, HI}, {32'b0, eh});
        check({name, "_lo"}, {32'b0, LO}, {32'b0, el});
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] eh, input logic [7:0] el, input string name);
        int n;
        @(negedge clock);
        start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            start8 = 1'b0;
        end while (!done8 && n < 100);
        check({name, "_latency"}, 64'(n), 64'(N8 + 1));
        check({name, "_hi"}, {56'b0, hi8}, {56'b0, eh});
        check({name, "_lo"}, {56'b0, lo8}, {56'b0, el});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rp;
        logic [31:0] ra, rb;
        logic        rs;
        int          dones;

        repeat (3) @(negedge clock);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, HI}, 64'd0);
        check("rst_lo", {32'b0, LO}, 64'd0);
        clear = 1'b1;
        chk_en = 1'b1;

        check("pin_7x-3", ref_prod(32'd7, 32'hFFFF_FFFD, 1'b1, W), 64'hFFFF_FFFF_FFFF_FFEB);
        check("pin_ffu", ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, W), 64'hFFFF_FFFE_0000_0001);
        check("pin_8x7f", ref_prod(32'h80, 32'h7F, 1'b1, W8), 64'h0000_0000_0000_C080);

        run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "s7xm3", 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "ffu", 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001, "ffs", 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, "mins", 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, "minu", 1'b0, 1'b0);
        run_op(32'h0, 32'h0, 1'b1, 32'h0, 32'h0, "zero", 1'b0, 1'b0);
        run_op(32'd1000, 32'd1000, 1'b0, 32'h0, 32'h000F_4240, "ignored_start", 1'b1, 1'b0);
        run_op(32'd5, 32'd6, 1'b1, 32'h0, 32'd30, "back2back", 1'b0, 1'b1);

        // Abort mid-operation; previous result (30) must be wiped asynchronously.
        @(negedge clock);
        go(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (10) begin
            @(negedge clock);
            start = 1'b0;
        end
        #1 clear = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hi", {32'b0, HI}, 64'd0);
        check("abort_lo", {32'b0, LO}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        dones = 0;
        repeat (N32 + 5) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "after_abort", 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = pick();
            rb = pick();
            rs = 1'($urandom);
            rp = ref_prod(ra, rb, rs, W);
            run_op(ra, rb, rs, rp[63:32], rp[31:0], "rand", 1'($urandom_range(0, 3) == 0),
                   1'($urandom));
        end

        op8(8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80, "w8_dir");
        for (int i = 0; i < 12; i++) begin
            ra = {24'b0, 8'($urandom)};
            rb = {24'b0, 8'($urandom)};
            rs = 1'($urandom);
            rp = ref_prod(ra, rb, rs, W8);
            op8(ra[7:0], rb[7:0], rs, rp[15:8], rp[7:0], "w8_rand");
        end

        repeat (3) @(negedge clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
